sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Message-schedule stage sitting directly upstream of the SHA-256 round/compression core.
- Accepts one 512-bit message block and streams the expanded schedule words W[0]..W[ROUNDS-1], one word per accepted handshake.
- The compression core consumes one W per round.
- Uses a 16-word sliding window, so no 64-word storage is needed.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- block_valid  input  1  block_in holds a valid block
- block_ready  output  1  block accepted when block_valid && block_ready
- block_in  input  512  message words; M0 = [511:480] ... M15 = [31:0]
- w_valid  output  1  w_out holds a valid schedule word
- w_ready  input  1  consumer accepts w_out on w_valid && w_ready
- w_out  output  32  current schedule word W[round]
- round  output  6  index of w_out (0..ROUNDS-1)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (reset == 0, takes effect immediately, independent of clk):
  - state = IDLE; window cleared to 0; round = 0.
  - block_ready = 0 while reset is held, 1 after release.
  - w_valid = 0; w_out = 0; busy = 0; done = 0.
- State machine, two states:
  - IDLE:
    - block_ready = 1, w_valid = 0, busy = 0.
    - On block_valid && block_ready: load window win[i] = M_i for i = 0..15, set round = 0, go to RUN.
  - RUN:
    - block_ready = 0, busy = 1, w_valid = 1, w_out = win[0].
    - On w_valid && w_ready: shift win[i] <= win[i+1] for i = 0..14, win[15] <= nxt, round <= round + 1.
    - If round == ROUNDS-1 at that handshake: return to IDLE, round <= 0, and assert done for exactly the next cycle.
- Next-word arithmetic (all additions mod 2^32; carries discarded, no saturation):
  - nxt = s1(win[14]) + win[9] + s0(win[1]) + win[0].
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Effect: for t < 16, W[t] = M_t; for t >= 16, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  - nxt is computed combinationally from registered window state. w_out is a register output: no combinational path from any input to w_out.
- Latency and throughput:
  - Block accepted at edge N → w_valid = 1 with W[0] in cycle N+1.
  - With w_ready held at 1, W[t] is presented in cycle N+1+t, i.e. one word per cycle.
  - Final word at N+ROUNDS; done pulses at N+ROUNDS+1, in the same cycle block_ready returns to 1.
- Backpressure: while w_valid && !w_ready, w_out, round and window are held unchanged, with no limit on stall length.
- block_valid while busy: ignored; no load and no state disturbance. Upstream holds block_in until accepted.
- block_in is sampled only on the accepting edge; later changes to it have no effect.
- Boundary conditions:
  - round never exceeds ROUNDS-1.
  - With ROUNDS = 16 no generated word is ever emitted: W equals M_0..M_15.
- Reset mid-RUN: aborts immediately. All outputs take their reset values; the partial block is discarded and no done is emitted.
- done and w_valid are never high in the same cycle.

Test Plan:
- "abc" block (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), w_ready = 1 → W[0] = 0x61626380, W[15] = 0x00000018, W[16] = 0x61626380, W[17] = 0x000F0000, W[63] = 0x12B1EDEB. Exactly 64 w_valid cycles; done one cycle after W[63]; block_ready high that same cycle.
- All-ones block (every M_i = 0xFFFFFFFF) → W[16] = 0x203FFFFC, exercising modular wrap-around; round sequence 0..63 with no gaps.
- "abc" block with w_ready driven low for 3 cycles while round == 20 → w_out and round hold at 20 for 4 cycles total; resulting W sequence identical to the unstalled run.
- block_valid held high with a different block_in during RUN → block_ready stays 0; the W stream matches the first block; the second block is accepted only after done.
- reset driven to 0 mid-cycle at round 30 → w_valid, busy, done and w_out go to 0 and round to 0 without waiting for a clk edge. After release, block_ready = 1 and a fresh "abc" block reproduces the reference W sequence.
- ROUNDS = 16 build with "abc" block → W[0..15] = M0..M15 in order; done after W[15].

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the SHA-256 message-schedule stage and its
// neighbours.
//   block_valid/block_ready/block_in : 512-bit message block from upstream
//   w_valid/w_ready/w_out/round      : expanded schedule word stream
//   busy/done                        : status (busy while streaming, done pulse)
// The slave modport is the schedule stage. The master modport is the side
// that supplies blocks and consumes words.
interface sha256_msg_schedule_if;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   round;
    logic         busy;
    logic         done;

    modport master (
        output block_valid, block_in, w_ready,
        input  block_ready, w_valid, w_out, round, busy, done
    );

    modport slave (
        input  block_valid, block_in, w_ready,
        output block_ready, w_valid, w_out, round, busy, done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule stage.
// Takes one 512-bit block (M0 in [511:480] .. M15 in [31:0]) and streams
// W[0]..W[ROUNDS-1], one word per w_valid/w_ready handshake. A 16-word
// sliding window replaces the full 64-word schedule: the head of the window
// is the current word, and each accepted word shifts in the next expanded
// word.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : sha256_msg_schedule_if slave (block input, word output, status)
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    sha256_msg_schedule_if.slave        bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    logic [0:0]  state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  round_q, round_d;
    logic        done_q, done_d;
    logic [31:0] nxt;
    logic        blk_fire;
    logic        w_fire;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // block_ready is gated by reset so it reads 0 for as long as reset is held
    assign blk_fire = bus.block_valid && bus.block_ready;
    assign w_fire   = (state_q == RUN) && bus.w_ready;

    // Window index 0 is W[t]; index k is W[t+k]. The next word entering at
    // index 15 is W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
    assign nxt = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        if (state_q == IDLE) begin
            if (blk_fire) begin
                for (int i = 0; i < 16; i++) begin
                    win_d[i] = bus.block_in[511 - 32*i -: 32];
                end
                round_d = '0;
                state_d = RUN;
            end
        end else begin
            if (w_fire) begin
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i + 1];
                end
                win_d[15] = nxt;
                if (round_q == LAST_ROUND) begin
                    // done lands in the first IDLE cycle, so it never overlaps w_valid
                    state_d = IDLE;
                    round_d = '0;
                    done_d  = 1'b1;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // w_out is masked to 0 outside RUN so stale window contents never leak out
    assign bus.block_ready = reset && (state_q == IDLE);
    assign bus.w_valid     = (state_q == RUN);
    assign bus.busy        = (state_q == RUN);
    assign bus.w_out       = (state_q == RUN) ? win_q[0] : 32'd0;
    assign bus.round       = round_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule.
// Two instances share clk/reset: ROUNDS=64 (main) and ROUNDS=16. A reference
// model expands each accepted block with the textbook W[t] recurrence, and
// one negedge process compares every DUT output cycle against it.
module tb_sha256_msg_schedule;

    localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] ONES_BLK = {16{32'hFFFFFFFF}};

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sha256_msg_schedule_if bus64 ();
    sha256_msg_schedule_if bus16 ();

    sha256_msg_schedule #(.ROUNDS(64)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64.slave)
    );

    sha256_msg_schedule #(.ROUNDS(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    int          checks = 0;
    int          errors = 0;
    bit          chk_on = 1'b0;
    logic [31:0] exp_w [2][64];
    logic [31:0] seen  [2][64];
    int          idx [2];
    bit          running [2];
    bit          done_exp [2];
    int          blocks_done [2];
    int          valid_cycles [2];
    int          stall_count = 0;

    // Reference model: plain rotate-by-concatenation and the full 64-word recurrence
    function automatic logic [31:0] mrotr(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x};
        return xx[n +: 32];
    endfunction

    function automatic logic [31:0] msig0(input logic [31:0] x);
        return mrotr(x, 7) ^ mrotr(x, 18) ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] msig1(input logic [31:0] x);
        return mrotr(x, 17) ^ mrotr(x, 19) ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] modelWord(input logic [511:0] blk, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = msig1(w[i-2]) + w[i-7] + msig0(w[i-15]) + w[i-16];
        return w[t];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-instance comparison against the model for one negedge sample
    task automatic compareInst(input int k, input int rounds,
                               input logic done, input logic busy, input logic wv,
                               input logic br, input logic bv, input logic [511:0] bin,
                               input logic [31:0] wo, input logic [5:0] rd, input logic wr);
        checkOutput($sformatf("done%0d", k), 32'(done), 32'(done_exp[k]));
        done_exp[k] = 1'b0;
        checkOutput($sformatf("busy%0d", k), 32'(busy), 32'(running[k]));
        checkOutput($sformatf("w_valid%0d", k), 32'(wv), 32'(running[k]));
        checkOutput($sformatf("block_ready%0d", k), 32'(br), 32'(!running[k]));
        if (running[k]) begin
            valid_cycles[k]++;
            if (k == 0 && rd == 6'd20) stall_count++;
            checkOutput($sformatf("w_out%0d_r%0d", k, idx[k]), wo, exp_w[k][idx[k]]);
            checkOutput($sformatf("round%0d", k), 32'(rd), 32'(idx[k]));
            seen[k][idx[k]] = wo;
            if (wr) begin
                idx[k]++;
                if (idx[k] == rounds) begin
                    running[k]  = 1'b0;
                    done_exp[k] = 1'b1;
                    blocks_done[k]++;
                end
            end
        end else if (bv) begin
            for (int t = 0; t < 64; t++) exp_w[k][t] = modelWord(bin, t);
            idx[k]          = 0;
            running[k]      = 1'b1;
            valid_cycles[k] = 0;
        end
    endtask

    // Single compare process: every cycle, both instances, while checking is enabled
    always @(negedge clk) begin
        if (!reset || !chk_on) begin
            for (int k = 0; k < 2; k++) begin
                running[k]  = 1'b0;
                idx[k]      = 0;
                done_exp[k] = 1'b0;
            end
        end else begin
            compareInst(0, 64, bus64.done, bus64.busy, bus64.w_valid, bus64.block_ready,
                        bus64.block_valid, bus64.block_in, bus64.w_out, bus64.round, bus64.w_ready);
            compareInst(1, 16, bus16.done, bus16.busy, bus16.w_valid, bus16.block_ready,
                        bus16.block_valid, bus16.block_in, bus16.w_out, bus16.round, bus16.w_ready);
        end
    end

    // Present a block, hold it until accepted, then withdraw it
    task automatic applyStimulus(input int k, input logic [511:0] blk);
        bit acc;
        int n;
        @(posedge clk); #1;
        if (k == 0) begin bus64.block_valid = 1'b1; bus64.block_in = blk; end
        else        begin bus16.block_valid = 1'b1; bus16.block_in = blk; end
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (k == 0) ? bus64.block_ready : bus16.block_ready;
            n++;
        end
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (k == 0) bus64.block_valid = 1'b0;
        else        bus16.block_valid = 1'b0;
    endtask

    task automatic waitBlocks(input int k, input int target);
        int n;
        n = 0;
        while (blocks_done[k] < target && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        if (blocks_done[k] < target) checkOutput("block_timeout", 32'(blocks_done[k]), 32'(target));
    endtask

    task automatic waitRound(input logic [5:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus64.w_valid && bus64.round == r) && n < 500);
        if (!(bus64.w_valid && bus64.round == r)) checkOutput("round_timeout", 32'(bus64.round), 32'(r));
    endtask

    initial begin
        reset = 1'b0;
        bus64.block_valid = 1'b0; bus64.block_in = '0; bus64.w_ready = 1'b1;
        bus16.block_valid = 1'b0; bus16.block_in = '0; bus16.w_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin blocks_done[k] = 0; valid_cycles[k] = 0; end

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_block_ready", 32'(bus64.block_ready), 32'd0);
        checkOutput("rst_w_valid", 32'(bus64.w_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus64.busy), 32'd0);
        checkOutput("rst_done", 32'(bus64.done), 32'd0);
        checkOutput("rst_w_out", bus64.w_out, 32'd0);
        checkOutput("rst_round", 32'(bus64.round), 32'd0);
        reset  = 1'b1;
        chk_on = 1'b1;

        // Pin the model to known SHA-256 schedule values
        checkOutput("model_abc_w16", modelWord(ABC_BLK, 16), 32'h61626380);
        checkOutput("model_abc_w17", modelWord(ABC_BLK, 17), 32'h000F0000);
        checkOutput("model_abc_w63", modelWord(ABC_BLK, 63), 32'h12B1EDEB);
        checkOutput("model_ones_w16", modelWord(ONES_BLK, 16), 32'h203FFFFC);

        // "abc" block, unstalled
        applyStimulus(0, ABC_BLK);
        waitBlocks(0, 1);
        checkOutput("abc_valid_cycles", 32'(valid_cycles[0]), 32'd64);
        checkOutput("abc_w0", seen[0][0], 32'h61626380);
        checkOutput("abc_w15", seen[0][15], 32'h00000018);
        checkOutput("abc_w17", seen[0][17], 32'h000F0000);
        checkOutput("abc_w63", seen[0][63], 32'h12B1EDEB);

        // All-ones block: modular wrap-around
        applyStimulus(0, ONES_BLK);
        waitBlocks(0, 2);
        checkOutput("ones_w16", seen[0][16], 32'h203FFFFC);

        // Backpressure: three stalled cycles while round 20 is presented
        stall_count = 0;
        applyStimulus(0, ABC_BLK);
        waitRound(6'd19);
        @(posedge clk); #1;
        bus64.w_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus64.w_ready = 1'b1;
        waitBlocks(0, 3);
        checkOutput("stall_round20_cycles", 32'(stall_count), 32'd4);
        checkOutput("stall_w63", seen[0][63], 32'h12B1EDEB);

        // Second block offered during RUN: must wait until the first completes
        @(posedge clk); #1;
        bus64.block_valid = 1'b1;
        bus64.block_in    = ABC_BLK;
        @(negedge clk);
        @(posedge clk); #1;
        bus64.block_in = ONES_BLK;
        waitBlocks(0, 4);
        checkOutput("overlap_first_w63", seen[0][63], 32'h12B1EDEB);
        @(negedge clk);
        @(posedge clk); #1;
        bus64.block_valid = 1'b0;
        waitBlocks(0, 5);
        checkOutput("overlap_second_w16", seen[0][16], 32'h203FFFFC);

        // Asynchronous reset in the middle of a block
        applyStimulus(0, ABC_BLK);
        waitRound(6'd30);
        chk_on = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_w_valid", 32'(bus64.w_valid), 32'd0);
        checkOutput("midrst_busy", 32'(bus64.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus64.done), 32'd0);
        checkOutput("midrst_w_out", bus64.w_out, 32'd0);
        checkOutput("midrst_round", 32'(bus64.round), 32'd0);
        checkOutput("midrst_block_ready", 32'(bus64.block_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("midrst_hold_round", 32'(bus64.round), 32'd0);
        reset  = 1'b1;
        chk_on = 1'b1;
        #1;
        checkOutput("postrst_block_ready", 32'(bus64.block_ready), 32'd1);
        applyStimulus(0, ABC_BLK);
        waitBlocks(0, 6);
        checkOutput("postrst_w63", seen[0][63], 32'h12B1EDEB);

        // ROUNDS = 16 instance: raw message words only
        applyStimulus(1, ABC_BLK);
        waitBlocks(1, 1);
        checkOutput("r16_valid_cycles", 32'(valid_cycles[1]), 32'd16);
        checkOutput("r16_w0", seen[1][0], 32'h61626380);
        checkOutput("r16_w15", seen[1][15], 32'h00000018);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
